rsa_job_sched: RTL and testbench

- Shares one rsa_core modular-exponentiation engine between NUM_REQ independent requesters.
- Round-robin arbitration over valid requests; latches the winner's operands and sequences the core's start/done handshake.
- Returns the result with the requester ID on a single valid/ready response channel.
- Rejects a zero modulus without starting the core, and drops a stuck job after a watchdog timeout.

---
 rtl/rsa_pkg.sv | 28 ++
 rtl/rsa_job_sched_if.sv | 44 ++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/rsa_job_sched.sv | 162 ++++++++++++++++
 tb/tb_rsa_job_sched.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA job scheduler: FSM encoding, default sizes, ID width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rsa_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_RESP    = 3'd4
  } state_t;

  // Bits needed to index n items; never less than 1.
  function automatic int id_w(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 31; k++) begin
      if ((1 << w) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rsa_job_sched_if.sv
// Bundle of requester, response and rsa_core signals seen by the job scheduler.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on the response channel, one-hot ready pulses on requests.
interface rsa_job_sched_if
  import rsa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_m;
  logic [NUM_REQ*WIDTH-1:0] req_e;
  logic [NUM_REQ*WIDTH-1:0] req_n;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_err;

  logic                     core_start;
  logic [WIDTH-1:0]         core_m;
  logic [WIDTH-1:0]         core_e;
  logic [WIDTH-1:0]         core_n;
  logic [WIDTH-1:0]         core_out;
  logic                     core_busy;
  logic                     core_done;

  // Scheduler side.
  modport master (
    input  req_valid, req_m, req_e, req_n, rsp_ready, core_out, core_busy, core_done,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_start, core_m, core_e, core_n
  );

  // Requesters, response consumer and core side.
  modport slave (
    output req_valid, req_m, req_e, req_n, rsp_ready, core_out, core_busy, core_done,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, core_start, core_m, core_e, core_n
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first active request at or after ptr (wrapping).
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_job_sched.sv
// Shares one rsa_core between NUM_REQ requesters: round-robin grant, operand latch, start/done
// sequencing, watchdog abort, zero-modulus reject. Latency: grant->core_start 1 cycle; response
// follows core drain. Backpressure: response held until rsp_ready; no new grant until it transfers.
// Ports: clk, rst_n (async active low), bus (master modport: req_*, rsp_*, core_*).
module rsa_job_sched
  import rsa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = id_w(NUM_REQ),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst_n,
  rsa_job_sched_if.master     bus
);

  localparam int WD_W = id_w(TIMEOUT);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 core_start_q, core_start_d;
  logic [WIDTH-1:0]     core_m_q, core_m_d;
  logic [WIDTH-1:0]     core_e_q, core_e_d;
  logic [WIDTH-1:0]     core_n_q, core_n_d;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 grant_any;
  logic                 grant_win;
  logic                 core_idle;
  logic                 wd_expired;
  logic [WIDTH-1:0]     sel_m, sel_e, sel_n;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign sel_m      = bus.req_m[grant_idx*WIDTH +: WIDTH];
  assign sel_e      = bus.req_e[grant_idx*WIDTH +: WIDTH];
  assign sel_n      = bus.req_n[grant_idx*WIDTH +: WIDTH];
  assign core_idle  = !bus.core_busy && !bus.core_done;
  // Leaving IDLE the same edge as the grant keeps req_ready a single-cycle pulse.
  assign grant_win  = (state_q == ST_IDLE) && core_idle && grant_any;
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (grant_win) state_d = (sel_n == '0) ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   if (bus.core_done) state_d = ST_CAPTURE;
                  else if (wd_expired) state_d = ST_DRAIN;
      ST_CAPTURE: state_d = ST_DRAIN;
      ST_DRAIN:   if (core_idle) state_d = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wd_d         = '0;
    req_ready_d  = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    core_start_d = core_start_q;
    core_m_d     = core_m_q;
    core_e_d     = core_e_q;
    core_n_d     = core_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_win) begin
          req_ready_d = grant;
          rr_ptr_d    = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
          core_m_d    = sel_m;
          core_e_d    = sel_e;
          core_n_d    = sel_n;
          rsp_id_d    = grant_idx;
          rsp_data_d  = '0;
          if (sel_n == '0) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
          end else begin
            rsp_err_d    = 1'b0;
            core_start_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        wd_d = wd_q + 1'b1;
        if (bus.core_done) begin
          core_start_d = 1'b0;
          rsp_data_d   = bus.core_out;
          rsp_err_d    = 1'b0;
        end else if (wd_expired) begin
          core_start_d = 1'b0;
          rsp_data_d   = '0;
          rsp_err_d    = 1'b1;
        end
      end
      ST_DRAIN: if (core_idle) rsp_valid_d = 1'b1;
      ST_RESP:  if (bus.rsp_ready) rsp_valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      wd_q         <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      core_start_q <= 1'b0;
      core_m_q     <= '0;
      core_e_q     <= '0;
      core_n_q     <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wd_q         <= wd_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      core_start_q <= core_start_d;
      core_m_q     <= core_m_d;
      core_e_q     <= core_e_d;
      core_n_q     <= core_n_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.core_start = core_start_q;
  assign bus.core_m     = core_m_q;
  assign bus.core_e     = core_e_q;
  assign bus.core_n     = core_n_q;

endmodule

// File: tb/tb_rsa_job_sched.sv
// Directed bench for rsa_job_sched with a behavioural rsa_core and a scoreboard of expected responses.
// Latency: n/a.
// Backpressure: consumer ready driven per test.
`timescale 1ns/1ps
module tb_rsa_job_sched;
  import rsa_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 64;
  localparam int CORE_LAT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_job_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  rsa_job_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Requester / consumer / core stimulus
  logic [NUM_REQ-1:0] rv;
  logic [WIDTH-1:0]   op_m [NUM_REQ];
  logic [WIDTH-1:0]   op_e [NUM_REQ];
  logic [WIDTH-1:0]   op_n [NUM_REQ];
  logic               rsp_rdy;
  logic               m_busy, m_done, hang;
  logic [WIDTH-1:0]   m_out;

  assign bus.req_valid = rv;
  assign bus.rsp_ready = rsp_rdy;
  assign bus.core_busy = m_busy;
  assign bus.core_done = m_done;
  assign bus.core_out  = m_out;

  always_comb begin
    bus.req_m = '0;
    bus.req_e = '0;
    bus.req_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_m[i*WIDTH +: WIDTH] = op_m[i];
      bus.req_e[i*WIDTH +: WIDTH] = op_e[i];
      bus.req_n[i*WIDTH +: WIDTH] = op_n[i];
    end
  end

  // Scoreboard state
  typedef struct {
    int             id;
    logic [WIDTH-1:0] data;
    logic           err;
    logic [WIDTH-1:0] m, e, n;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   rsp_id_log[$];
  logic [WIDTH-1:0] rsp_data_log[$];
  logic rsp_err_log[$];
  int   rsp_count = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic cs_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [WIDTH-1:0] modexp(input logic [WIDTH-1:0] m, e, n);
    logic [31:0] r, b, nn;
    if (n == '0) return '0;
    nn = {16'd0, n};
    r  = 32'd1 % nn;
    b  = {16'd0, m} % nn;
    for (int i = 0; i < WIDTH; i++) begin
      if (e[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[WIDTH-1:0];
  endfunction

  // Behavioural rsa_core: busy while computing, done held while start stays high.
  // In hang mode it never finishes and stays busy a few cycles after start drops.
  initial begin
    int phase, cnt;
    phase = 0; cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_out = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        phase = 0; m_busy = 1'b0; m_done = 1'b0; m_out = '0;
      end else begin
        case (phase)
          0: if (bus.core_start) begin phase = 1; m_busy = 1'b1; cnt = CORE_LAT; end
          1: begin
            if (!bus.core_start) begin phase = 3; cnt = 4; end
            else if (!hang) begin
              if (cnt == 0) begin
                phase = 2; m_done = 1'b1;
                m_out = modexp(bus.core_m, bus.core_e, bus.core_n);
              end else cnt--;
            end
          end
          2: if (!bus.core_start) begin phase = 0; m_busy = 1'b0; m_done = 1'b0; end
          default: begin
            if (cnt == 0) begin phase = 0; m_busy = 1'b0; end
            else cnt--;
          end
        endcase
      end
    end
  end

  // Grant monitor: builds expectations from req_ready pulses and retires the request.
  initial begin
    logic prev_start, prev_done;
    prev_start = 1'b0; prev_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_start = 1'b0; prev_done = 1'b0;
      end else begin
        if (prev_start && prev_done) chk("start_low_after_done", {31'd0, bus.core_start}, 32'd0);
        prev_start = bus.core_start;
        prev_done  = bus.core_done;
        if (bus.req_ready != '0) begin
          chk("ready_onehot", {31'd0, $onehot(bus.req_ready)}, 32'd1);
          chk("one_job_in_flight", exp_q.size(), 32'd0);
          for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
              exp_t x;
              x.id   = i;
              x.m    = op_m[i];
              x.e    = op_e[i];
              x.n    = op_n[i];
              x.err  = (op_n[i] == '0) || hang;
              x.data = x.err ? '0 : modexp(op_m[i], op_e[i], op_n[i]);
              exp_q.push_back(x);
              grant_log.push_back(i);
              rv[i] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Compare process: core operands while started, responses on transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.core_start) begin
          cs_seen = 1'b1;
          if (exp_q.size() == 0) chk("start_without_grant", 32'd1, 32'd0);
          else begin
            chk("core_m", {16'd0, bus.core_m}, {16'd0, exp_q[0].m});
            chk("core_e", {16'd0, bus.core_e}, {16'd0, exp_q[0].e});
            chk("core_n", {16'd0, bus.core_n}, {16'd0, exp_q[0].n});
          end
        end
        if (bus.rsp_valid) begin
          chk("core_idle_in_resp", {30'd0, bus.core_busy, bus.core_done}, 32'd0);
          if (exp_q.size() == 0) chk("rsp_without_grant", 32'd1, 32'd0);
          else if (bus.rsp_ready) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("rsp_id", {30'd0, bus.rsp_id}, x.id);
            chk("rsp_data", {16'd0, bus.rsp_data}, {16'd0, x.data});
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, x.err});
            rsp_id_log.push_back(int'(bus.rsp_id));
            rsp_data_log.push_back(bus.rsp_data);
            rsp_err_log.push_back(bus.rsp_err);
            rsp_count++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic req(input int i, input logic [WIDTH-1:0] m, e, n);
    op_m[i] = m; op_e[i] = e; op_n[i] = n; rv[i] = 1'b1;
  endtask

  task automatic wait_rsp(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (rsp_count < target && k < budget) begin tick(); k++; end
    if (rsp_count < target) chk({name, "_timeout"}, rsp_count, target);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, {28'd0, bus.req_ready}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, {16'd0, bus.rsp_data}, 32'd0);
    chk({tag, "_rsp_id"}, {30'd0, bus.rsp_id}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
    chk({tag, "_core_start"}, {31'd0, bus.core_start}, 32'd0);
    chk({tag, "_core_m"}, {16'd0, bus.core_m}, 32'd0);
    chk({tag, "_core_e"}, {16'd0, bus.core_e}, 32'd0);
    chk({tag, "_core_n"}, {16'd0, bus.core_n}, 32'd0);
  endtask

  initial begin
    int base, k, len;
    rv = '0; rsp_rdy = 1'b1; hang = 1'b0; cs_seen = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin op_m[i] = '0; op_e[i] = '0; op_n[i] = '0; end
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Burst of four identical jobs: grants 0..3, all results 26.
    for (int i = 0; i < NUM_REQ; i++) req(i, 16'd5, 16'd3, 16'd33);
    wait_rsp(4, 400, "burst1");
    chk("burst1_grants", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("burst1_order", grant_log[i], i);
    for (int i = 0; i < 4 && i < rsp_data_log.size(); i++) begin
      chk("burst1_data_lit", {16'd0, rsp_data_log[i]}, 32'd26);
      chk("burst1_id_lit", rsp_id_log[i], i);
    end
    tick();
    base = grant_log.size();
    for (int i = 0; i < NUM_REQ; i++) req(i, 16'd5, 16'd3, 16'd33);
    wait_rsp(8, 400, "burst2");
    if (grant_log.size() > base) chk("burst2_first_grant", grant_log[base], 32'd0);
    else chk("burst2_no_grant", grant_log.size(), base + 1);
    tick();

    // Single job from requester 1: 4^13 mod 497 = 445.
    req(1, 16'd4, 16'd13, 16'd497);
    wait_rsp(9, 200, "single");
    if (rsp_data_log.size() >= 9) begin
      chk("single_data_lit", {16'd0, rsp_data_log[8]}, 32'd445);
      chk("single_id_lit", rsp_id_log[8], 32'd1);
      chk("single_err_lit", {31'd0, rsp_err_log[8]}, 32'd0);
    end
    tick();

    // Zero modulus from requester 2: error, core never started.
    cs_seen = 1'b0;
    req(2, 16'd3, 16'd5, 16'd0);
    wait_rsp(10, 100, "nzero");
    if (rsp_data_log.size() >= 10) begin
      chk("nzero_err_lit", {31'd0, rsp_err_log[9]}, 32'd1);
      chk("nzero_data_lit", {16'd0, rsp_data_log[9]}, 32'd0);
      chk("nzero_id_lit", rsp_id_log[9], 32'd2);
    end
    chk("nzero_core_start_seen", {31'd0, cs_seen}, 32'd0);
    tick();

    // Zero exponent: 9^0 mod 7 = 1, then modulus 1 gives 0.
    req(3, 16'd9, 16'd0, 16'd7);
    wait_rsp(11, 200, "ezero");
    tick();
    req(0, 16'd9, 16'd0, 16'd1);
    wait_rsp(12, 200, "nOne");
    if (rsp_data_log.size() >= 12) begin
      chk("ezero_data_lit", {16'd0, rsp_data_log[10]}, 32'd1);
      chk("none_data_lit", {16'd0, rsp_data_log[11]}, 32'd0);
    end
    tick();

    // Backpressure: result for requester 0 held 10 cycles while requester 3 waits.
    rsp_rdy = 1'b0;
    req(0, 16'd5, 16'd3, 16'd33);
    k = 0;
    while (!bus.rsp_valid && k < 200) begin tick(); k++; end
    if (!bus.rsp_valid) chk("bp_valid_timeout", 32'd0, 32'd1);
    req(3, 16'd4, 16'd13, 16'd497);
    base = grant_log.size();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_data", {16'd0, bus.rsp_data}, 32'd26);
      chk("bp_id", {30'd0, bus.rsp_id}, 32'd0);
      chk("bp_ready_held", {28'd0, bus.req_ready}, 32'd0);
    end
    chk("bp_no_new_grant", grant_log.size(), base);
    tick();
    rsp_rdy = 1'b1;
    wait_rsp(14, 300, "bp_follow");
    if (grant_log.size() > base) chk("bp_follow_grant", grant_log[base], 32'd3);
    else chk("bp_follow_missing", grant_log.size(), base + 1);
    tick();

    // Watchdog: core never finishes; core_start held exactly TIMEOUT cycles.
    hang = 1'b1;
    req(1, 16'd2, 16'd2, 16'd11);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!bus.core_start && k < 50);
    len = 0;
    while (bus.core_start && len < 200) begin len++; @(posedge clk); #1; end
    chk("timeout_start_cycles", len, TIMEOUT);
    wait_rsp(15, 100, "timeout");
    if (rsp_err_log.size() >= 15) begin
      chk("timeout_err_lit", {31'd0, rsp_err_log[14]}, 32'd1);
      chk("timeout_data_lit", {16'd0, rsp_data_log[14]}, 32'd0);
    end
    tick();

    // Reset during ISSUE: outputs clear immediately, no response follows.
    req(2, 16'd7, 16'd3, 16'd13);
    k = 0;
    do begin tick(); k++; end while (!bus.core_start && k < 50);
    repeat (5) tick();
    rst_n = 1'b0;
    exp_q.delete();
    rv = '0;
    #1;
    check_all_zero("midrst");
    repeat (3) tick();
    hang = 1'b0;
    rst_n = 1'b1;
    base = rsp_count;
    repeat (20) tick();
    chk("midrst_no_rsp", rsp_count, base);
    chk("end_queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
